// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-flop sync, press/release debounce FSM,
// press/release/long-press strobes and a wrapping press counter per key.
module key_debounce_multi #(
    parameter int N_KEYS      = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int CNT_W       = 4,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_KEYS-1:0]         key_in,
    input  logic [N_KEYS-1:0]         cnt_clr,
    output logic [N_KEYS-1:0]         key_state,
    output logic [N_KEYS-1:0]         press_pulse,
    output logic [N_KEYS-1:0]         release_pulse,
    output logic [N_KEYS-1:0]         long_pulse,
    output logic [N_KEYS*CNT_W-1:0]   press_cnt
);

    localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
    localparam int TMR_MAX  = (DB_CYC > LONG_CYC) ? DB_CYC : LONG_CYC;
    localparam int TW       = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0] DB_T   = TW'(DB_CYC);
    localparam logic [TW-1:0] LONG_T = TW'(LONG_CYC - 1);

    generate
        if (DB_CYC < 1 || LONG_CYC < 1 || N_KEYS < 1 || CNT_W < 1) begin : g_bad_cfg
            $error("key_debounce_multi: DB_CYC/LONG_CYC/N_KEYS/CNT_W must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch

        logic              raw;
        logic              sync1;
        logic              s;
        state_t            st;
        logic [TW-1:0]     db_tmr;
        logic [TW-1:0]     hold_tmr;
        logic              long_done;
        logic              ks_q;
        logic              pp_q;
        logic              rp_q;
        logic              lp_q;
        logic [CNT_W-1:0]  cnt_q;

        // Normalise before synchronising so reset can load 0 as "released".
        assign raw = (ACTIVE_LOW != 0) ? ~key_in[i] : key_in[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1 <= 1'b0;
                s     <= 1'b0;
            end else begin
                sync1 <= raw;
                s     <= sync1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st        <= IDLE;
                db_tmr    <= '0;
                hold_tmr  <= '0;
                long_done <= 1'b0;
                ks_q      <= 1'b0;
                pp_q      <= 1'b0;
                rp_q      <= 1'b0;
                lp_q      <= 1'b0;
            end else begin
                pp_q <= 1'b0;
                rp_q <= 1'b0;
                lp_q <= 1'b0;
                unique case (st)
                    IDLE: begin
                        if (s) begin
                            st     <= PRESS_DB;
                            db_tmr <= TW'(1);
                        end
                    end
                    PRESS_DB: begin
                        if (!s) begin
                            st     <= IDLE;
                            db_tmr <= '0;
                        end else if (db_tmr == DB_T) begin
                            st        <= HELD;
                            db_tmr    <= '0;
                            hold_tmr  <= '0;
                            long_done <= 1'b0;
                            ks_q      <= 1'b1;
                            pp_q      <= 1'b1;
                        end else begin
                            db_tmr <= db_tmr + TW'(1);
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            st     <= RELEASE_DB;
                            db_tmr <= TW'(1);
                        end else if (!long_done) begin
                            // Hold timer stops once the long strobe has fired.
                            if (hold_tmr == LONG_T) begin
                                lp_q      <= 1'b1;
                                long_done <= 1'b1;
                            end else begin
                                hold_tmr <= hold_tmr + TW'(1);
                            end
                        end
                    end
                    RELEASE_DB: begin
                        if (s) begin
                            st     <= HELD;
                            db_tmr <= '0;
                        end else if (db_tmr == DB_T) begin
                            st     <= IDLE;
                            db_tmr <= '0;
                            ks_q   <= 1'b0;
                            rp_q   <= 1'b1;
                        end else begin
                            db_tmr <= db_tmr + TW'(1);
                        end
                    end
                endcase
            end
        end

        // Clear wins over an increment landing on the same edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (cnt_clr[i]) begin
                cnt_q <= '0;
            end else if (pp_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign key_state[i]                 = ks_q;
        assign press_pulse[i]               = pp_q;
        assign release_pulse[i]             = rp_q;
        assign long_pulse[i]                = lp_q;
        assign press_cnt[i*CNT_W +: CNT_W]  = cnt_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: 2 keys, DB_CYC=4, LONG_CYC=10.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_key_debounce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_in;
    logic [1:0] cnt_clr;
    logic [1:0] key_state;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;
    logic [5:0] press_cnt;

    always #5 clk = ~clk;

    key_debounce_multi #(
        .N_KEYS(2), .CLK_HZ(1000), .DEBOUNCE_MS(4),
        .LONG_MS(10), .CNT_W(3), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .cnt_clr(cnt_clr),
        .key_state(key_state),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .press_cnt(press_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_no   = 0;
    int ref_c    = 0;
    int viol     = 0;
    int pcnt[2];
    int rcnt[2];
    int lcnt[2];
    int pfst[2];
    int rfst[2];
    int lfst[2];
    logic [1:0] pp_q = '0;
    logic [1:0] rp_q = '0;
    logic [1:0] lp_q = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt0();
        return 32'(press_cnt[2:0]);
    endfunction

    function automatic logic [31:0] cnt1();
        return 32'(press_cnt[5:3]);
    endfunction

    task automatic mark();
        for (int c = 0; c < 2; c++) begin
            pcnt[c] = 0; rcnt[c] = 0; lcnt[c] = 0;
            pfst[c] = -1; rfst[c] = -1; lfst[c] = -1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
        for (int c = 0; c < 2; c++) begin
            if (press_pulse[c]) begin
                pcnt[c]++;
                if (pfst[c] < 0) pfst[c] = cyc_no;
            end
            if (release_pulse[c]) begin
                rcnt[c]++;
                if (rfst[c] < 0) rfst[c] = cyc_no;
            end
            if (long_pulse[c]) begin
                lcnt[c]++;
                if (lfst[c] < 0) lfst[c] = cyc_no;
            end
            if (int'(press_pulse[c]) + int'(release_pulse[c])
                + int'(long_pulse[c]) > 1) viol++;
        end
        if ((press_pulse & pp_q) != 0) viol++;
        if ((release_pulse & rp_q) != 0) viol++;
        if ((long_pulse & lp_q) != 0) viol++;
        pp_q = press_pulse;
        rp_q = release_pulse;
        lp_q = long_pulse;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        int w;
        rst     = 1'b1;
        key_in  = 2'b11;
        cnt_clr = 2'b00;
        mark();
        @(negedge clk);
        run(2);
        chk("rst_state", 32'(key_state), 0);
        chk("rst_pulses", 32'({press_pulse, release_pulse, long_pulse}), 0);
        chk("rst_cnt", 32'(press_cnt), 0);
        rst = 1'b0;
        run(5);

        // clean press on key 0
        mark();
        key_in[0] = 1'b0;
        ref_c = cyc_no;
        run(30);
        chk("t1_press_at", pfst[0] - ref_c, 7);
        chk("t1_press_n", pcnt[0], 1);
        chk("t1_long_at", lfst[0] - ref_c, 17);
        chk("t1_long_n", lcnt[0], 1);
        chk("t1_ch1_quiet", pcnt[1] + rcnt[1] + lcnt[1], 0);
        chk("t1_cnt0", cnt0(), 1);
        chk("t1_state", 32'(key_state), 1);
        mark();
        key_in[0] = 1'b1;
        ref_c = cyc_no;
        run(20);
        chk("t1_rel_at", rfst[0] - ref_c, 7);
        chk("t1_rel_n", rcnt[0], 1);
        chk("t1_state_rel", 32'(key_state), 0);

        // bounce on key 0
        cnt_clr = 2'b01;
        run(1);
        cnt_clr = 2'b00;
        chk("t2_clr", cnt0(), 0);
        mark();
        key_in[0] = 1'b0; run(2);
        key_in[0] = 1'b1; run(1);
        key_in[0] = 1'b0; run(2);
        key_in[0] = 1'b1; run(1);
        key_in[0] = 1'b0;
        ref_c = cyc_no;
        run(20);
        chk("t2_press_at", pfst[0] - ref_c, 7);
        chk("t2_press_n", pcnt[0], 1);
        chk("t2_no_rel", rcnt[0], 0);
        chk("t2_cnt0", cnt0(), 1);
        key_in[0] = 1'b1;
        run(20);

        // wrap and clear on key 1
        cnt_clr = 2'b10;
        run(1);
        cnt_clr = 2'b00;
        mark();
        for (int k = 0; k < 9; k++) begin
            key_in[1] = 1'b0; run(8);
            key_in[1] = 1'b1; run(10);
        end
        chk("t3_press_n", pcnt[1], 9);
        chk("t3_rel_n", rcnt[1], 9);
        chk("t3_wrap", cnt1(), 1);
        key_in[1] = 1'b0;
        w = 0;
        while (!press_pulse[1] && w < 20) begin
            cyc();
            w++;
        end
        chk("t3_pulse_seen", 32'(press_pulse[1]), 1);
        cnt_clr = 2'b10;
        cyc();
        cnt_clr = 2'b00;
        chk("t3_clr_wins", cnt1(), 0);
        run(3);
        chk("t3_clr_hold", cnt1(), 0);
        key_in[1] = 1'b1;
        run(12);

        // release bounce while held on key 0
        mark();
        key_in[0] = 1'b0;
        ref_c = cyc_no;
        run(15);
        key_in[0] = 1'b1; run(2);
        key_in[0] = 1'b0; run(30);
        chk("t4_press_n", pcnt[0], 1);
        chk("t4_no_rel", rcnt[0], 0);
        chk("t4_long_n", lcnt[0], 1);
        chk("t4_long_at", lfst[0] - ref_c, 17);
        chk("t4_state", 32'(key_state[0]), 1);
        key_in[0] = 1'b1;
        run(20);
        chk("t4_rel_n", rcnt[0], 1);
        chk("t4_long_once", lcnt[0], 1);

        // simultaneous press on both keys
        cnt_clr = 2'b11;
        run(1);
        cnt_clr = 2'b00;
        mark();
        key_in = 2'b00;
        ref_c = cyc_no;
        run(10);
        chk("t5_p0_at", pfst[0] - ref_c, 7);
        chk("t5_p1_at", pfst[1] - ref_c, 7);
        chk("t5_cnt0", cnt0(), 1);
        chk("t5_cnt1", cnt1(), 1);
        key_in = 2'b11;
        run(20);

        // reset mid-press: key 1 held, key 0 still debouncing
        key_in[1] = 1'b0; run(10);
        key_in[0] = 1'b0; run(4);
        rst = 1'b1;
        run(1);
        chk("t6_rst_state", 32'(key_state), 0);
        chk("t6_rst_pulses", 32'({press_pulse, release_pulse, long_pulse}), 0);
        chk("t6_rst_cnt", 32'(press_cnt), 0);
        rst = 1'b0;
        mark();
        ref_c = cyc_no;
        run(12);
        chk("t6_p0_at", pfst[0] - ref_c, 7);
        chk("t6_p1_at", pfst[1] - ref_c, 7);
        chk("t6_p0_n", pcnt[0], 1);
        chk("t6_no_rel", rcnt[0] + rcnt[1], 0);
        chk("t6_cnt0", cnt0(), 1);
        chk("t6_cnt1", cnt1(), 1);
        key_in = 2'b11;
        run(20);

        chk("pulse_rules", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
